// File: rtl/sseg_scan_controller_if.sv
// Load handshake between the display-value producer and the scan controller.
interface sseg_scan_controller_if;
    logic        load_valid;
    logic        load_ready;
    logic [15:0] load_value;
    logic [3:0]  load_dp;

    modport master (output load_valid, output load_value, output load_dp, input load_ready);
    modport slave  (input load_valid, input load_value, input load_dp, output load_ready);
endinterface

// File: rtl/sseg_scan_controller.sv
// 4-digit common-anode 7-segment scan controller: prescaled digit scan, inter-digit
// blanking, enable mask, leading-zero blanking, frame-synchronous double-buffered load.
module sseg_scan_controller #(
    parameter int unsigned PRESCALE     = 100000,
    parameter int unsigned BLANK_CYCLES = 1000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    sseg_scan_controller_if.slave   ld,
    input  logic [3:0]              digit_en,
    input  logic                    lz_blank,
    output logic [1:0]              refreshcounter,
    output logic [3:0]              anode,
    output logic [3:0]              nibble,
    output logic                    dp_n,
    output logic                    frame_done
);

    localparam int unsigned CW = $clog2(PRESCALE);

    localparam logic [1:0] S_OFF   = 2'd0;
    localparam logic [1:0] S_BLANK = 2'd1;
    localparam logic [1:0] S_DRIVE = 2'd2;

    logic [CW-1:0] cnt, cnt_nxt;
    logic [1:0]    rc_nxt;
    logic [1:0]    state, state_nxt;
    logic [15:0]   pending, active, active_nxt;
    logic [3:0]    pending_dp, active_dp, active_dp_nxt;
    logic          pending_full, pending_full_nxt;
    logic          wrap, boundary, swap, accept;
    logic          lzero, supp;
    logic [3:0]    anode_nxt, nibble_nxt;
    logic          dp_n_nxt;

    assign ld.load_ready = ~pending_full;

    // Outputs are registered from next-cycle values so they line up with the registered
    // refreshcounter/cnt.
    always_comb begin
        wrap             = (cnt == CW'(PRESCALE - 1));
        boundary         = wrap && (refreshcounter == 2'd3);
        swap             = boundary && pending_full;
        accept           = ld.load_valid && !pending_full;
        cnt_nxt          = wrap ? '0 : cnt + 1'b1;
        rc_nxt           = wrap ? refreshcounter + 2'd1 : refreshcounter;
        active_nxt       = swap ? pending : active;
        active_dp_nxt    = swap ? pending_dp : active_dp;
        pending_full_nxt = accept || (pending_full && !swap);

        state_nxt = state;
        if (state == S_OFF) begin
            if (swap) state_nxt = S_BLANK;
        end else if (cnt_nxt == '0) begin
            state_nxt = S_BLANK;
        end else if (cnt_nxt == CW'(BLANK_CYCLES)) begin
            state_nxt = S_DRIVE;
        end

        lzero = 1'b0;
        case (rc_nxt)
            2'd1:    lzero = (active_nxt[15:4] == '0);
            2'd2:    lzero = (active_nxt[15:8] == '0);
            2'd3:    lzero = (active_nxt[15:12] == '0);
            default: lzero = 1'b0;
        endcase
        supp = !digit_en[rc_nxt] || (lz_blank && lzero);

        nibble_nxt = active_nxt[{rc_nxt, 2'b00} +: 4];
        anode_nxt  = '1;
        dp_n_nxt   = 1'b1;
        if (state_nxt == S_DRIVE && !supp) begin
            anode_nxt          = '1;
            anode_nxt[rc_nxt]  = 1'b0;
            dp_n_nxt           = ~active_dp_nxt[rc_nxt];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt            <= '0;
            refreshcounter <= '0;
            state          <= S_OFF;
            pending        <= '0;
            pending_dp     <= '0;
            pending_full   <= 1'b0;
            active         <= '0;
            active_dp      <= '0;
            anode          <= '1;
            nibble         <= '0;
            dp_n           <= 1'b1;
            frame_done     <= 1'b0;
        end else begin
            cnt            <= cnt_nxt;
            refreshcounter <= rc_nxt;
            state          <= state_nxt;
            pending_full   <= pending_full_nxt;
            active         <= active_nxt;
            active_dp      <= active_dp_nxt;
            anode          <= anode_nxt;
            nibble         <= nibble_nxt;
            dp_n           <= dp_n_nxt;
            frame_done     <= swap;
            if (accept) begin
                pending    <= ld.load_value;
                pending_dp <= ld.load_dp;
            end
        end
    end

endmodule

// File: tb/tb_sseg_scan_controller.sv
// Directed bench for sseg_scan_controller with PRESCALE=8, BLANK_CYCLES=2.
module tb_sseg_scan_controller;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] digit_en = 4'b1111;
    logic       lz_blank = 1'b0;
    logic [1:0] refreshcounter;
    logic [3:0] anode;
    logic [3:0] nibble;
    logic       dp_n;
    logic       frame_done;
    int         tests = 0;
    int         fails = 0;
    int         k;

    sseg_scan_controller_if ld ();

    sseg_scan_controller #(.PRESCALE(8), .BLANK_CYCLES(2)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ld             (ld),
        .digit_en       (digit_en),
        .lz_blank       (lz_blank),
        .refreshcounter (refreshcounter),
        .anode          (anode),
        .nibble         (nibble),
        .dp_n           (dp_n),
        .frame_done     (frame_done)
    );

    always #5 clk = ~clk;

    // Cycles since reset release; slot = (k/8)%4, position in slot = k%8.
    always @(posedge clk or negedge rst_n)
        if (!rst_n) k <= 0;
        else        k <= k + 1;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s at k=%0d: got %h expected %h", tag, k, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    function automatic logic m_supp(input logic [15:0] v, input int slot);
        return !digit_en[slot] || (lz_blank && slot >= 1 && (v >> (4 * slot)) == 16'h0);
    endfunction

    function automatic logic [3:0] m_anode(input logic [15:0] v);
        int slot = (k / 8) % 4;
        logic [3:0] a = 4'b1111;
        if ((k % 8) >= 2 && !m_supp(v, slot)) a[slot] = 1'b0;
        return a;
    endfunction

    function automatic logic m_dpn(input logic [15:0] v, input logic [3:0] dp);
        int slot = (k / 8) % 4;
        if ((k % 8) >= 2 && !m_supp(v, slot)) return ~dp[slot];
        return 1'b1;
    endfunction

    function automatic logic [3:0] m_nib(input logic [15:0] v);
        int slot = (k / 8) % 4;
        return 4'((v >> (4 * slot)) & 16'hF);
    endfunction

    task automatic run(input int n, input logic [15:0] v, input logic [3:0] dp);
        for (int i = 0; i < n; i++) begin
            chk("rc", 16'(refreshcounter), 16'((k / 8) % 4));
            chk("anode", 16'(anode), 16'(m_anode(v)));
            chk("nibble", 16'(nibble), 16'(m_nib(v)));
            chk("dp_n", 16'(dp_n), 16'(m_dpn(v, dp)));
            step();
        end
    endtask

    task automatic wait_k(input int target);
        int n = 0;
        while ((k % 32) != target && n < 64) begin
            step();
            n++;
        end
        chk("wait_bound", 16'((k % 32) == target), 16'd1);
    endtask

    task automatic offer(input logic [15:0] v, input logic [3:0] dp);
        ld.load_valid = 1'b1;
        ld.load_value = v;
        ld.load_dp    = dp;
    endtask

    task automatic idle_dark(input int n);
        for (int i = 0; i < n; i++) begin
            chk("idle_anode", 16'(anode), 16'hF);
            chk("idle_rc", 16'(refreshcounter), 16'((k / 8) % 4));
            chk("idle_ready", 16'(ld.load_ready), 16'd1);
            chk("idle_fd", 16'(frame_done), 16'd0);
            step();
        end
    endtask

    initial begin
        ld.load_valid = 1'b0;
        ld.load_value = '0;
        ld.load_dp    = '0;
        repeat (2) step();
        rst_n = 1'b1;

        // Reset state
        chk("rst_anode", 16'(anode), 16'hF);
        chk("rst_rc", 16'(refreshcounter), 16'd0);
        chk("rst_nibble", 16'(nibble), 16'd0);
        chk("rst_dpn", 16'(dp_n), 16'd1);
        chk("rst_fd", 16'(frame_done), 16'd0);
        chk("rst_ready", 16'(ld.load_ready), 16'd1);

        // 1: idle, no load
        idle_dark(40);

        // 2: load 1234, dp on digit 2
        offer(16'h1234, 4'b0100);
        step();
        chk("t2_ready_low", 16'(ld.load_ready), 16'd0);
        ld.load_valid = 1'b0;
        wait_k(0);
        chk("t2_fd", 16'(frame_done), 16'd1);
        chk("t2_ready_back", 16'(ld.load_ready), 16'd1);
        run(32, 16'h1234, 4'b0100);
        chk("t2_no_swap", 16'(frame_done), 16'd0);

        // 3: leading-zero blanking, cleared mid-frame
        lz_blank = 1'b1;
        offer(16'h0070, 4'b0000);
        step();
        ld.load_valid = 1'b0;
        wait_k(0);
        chk("t3_fd", 16'(frame_done), 16'd1);
        run(32, 16'h0070, 4'b0000);
        run(12, 16'h0070, 4'b0000);
        lz_blank = 1'b0;
        run(20, 16'h0070, 4'b0000);

        // 4: back-to-back A then B
        wait_k(4);
        offer(16'hAAAA, 4'b0000);
        step();
        ld.load_value = 16'hBBBB;
        ld.load_dp    = 4'b1000;
        while ((k % 32) != 0) begin
            chk("t4_held_ready", 16'(ld.load_ready), 16'd0);
            chk("t4_held_fd", 16'(frame_done), 16'd0);
            step();
        end
        chk("t4_fdA", 16'(frame_done), 16'd1);
        chk("t4_readyA", 16'(ld.load_ready), 16'd1);
        chk("t4_nibA", 16'(nibble), 16'hA);
        step();
        chk("t4_B_taken", 16'(ld.load_ready), 16'd0);
        chk("t4_fd_pulse", 16'(frame_done), 16'd0);
        ld.load_valid = 1'b0;
        run(31, 16'hAAAA, 4'b0000);
        chk("t4_fdB", 16'(frame_done), 16'd1);
        run(32, 16'hBBBB, 4'b1000);

        // 5: load offered on the boundary cycle, digit 1 masked off
        digit_en = 4'b1101;
        wait_k(31);
        offer(16'h9005, 4'b0001);
        step();
        chk("t5_no_fd", 16'(frame_done), 16'd0);
        chk("t5_ready", 16'(ld.load_ready), 16'd0);
        ld.load_valid = 1'b0;
        run(32, 16'hBBBB, 4'b1000);
        chk("t5_fd", 16'(frame_done), 16'd1);
        chk("t5_ready_back", 16'(ld.load_ready), 16'd1);
        run(32, 16'h9005, 4'b0001);
        digit_en = 4'b1111;

        // 6: asynchronous reset mid-DRIVE
        wait_k(20);
        chk("t6_driving", 16'(anode), 16'b1011);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_anode", 16'(anode), 16'hF);
        chk("t6_dpn", 16'(dp_n), 16'd1);
        chk("t6_rc", 16'(refreshcounter), 16'd0);
        chk("t6_nibble", 16'(nibble), 16'd0);
        chk("t6_ready", 16'(ld.load_ready), 16'd1);
        step();
        rst_n = 1'b1;
        idle_dark(40);
        offer(16'h00C3, 4'b0010);
        step();
        ld.load_valid = 1'b0;
        wait_k(0);
        chk("t6_fd", 16'(frame_done), 16'd1);
        run(32, 16'h00C3, 4'b0010);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sseg_scan_controller.md
Name: sseg_scan_controller

Overview:
- Time-multiplexing controller for the 4-digit common-anode seven-segment display.
- Generates the 2-bit digit-select (refreshcounter) that drives the anode decoder, and produces the per-digit anode, hex nibble and decimal-point outputs.
- Adds inter-digit blanking against ghosting, a per-digit enable mask, and optional leading-zero blanking.
- Holds a double-buffered display value loaded through a valid/ready handshake and swapped only at frame boundaries, so a frame never shows a torn value.
- Sits between the value producer (counter/FSM) and the segment decoder/pins.

Parameters:
PRESCALE, 100000, clock cycles per digit slot; legal range 4..2^24.
BLANK_CYCLES, 1000, cycles at the start of each slot with all anodes off; must satisfy 1 <= BLANK_CYCLES < PRESCALE.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous, active-low reset
load_valid  input  1  producer offers load_value/load_dp
load_ready  output  1  high when the pending buffer is empty
load_value  input  16  four hex nibbles; [3:0] = digit 0 (rightmost)
load_dp  input  4  decimal-point enable per digit, 1 = lit
digit_en  input  4  per-digit enable mask, sampled live, 1 = enabled
lz_blank  input  1  leading-zero blanking enable, sampled live
refreshcounter  output  2  current digit index, 0 = rightmost
anode  output  4  active-low anode drive
nibble  output  4  hex value for the current digit, to the segment decoder
dp_n  output  1  active-low decimal point
frame_done  output  1  one-cycle pulse when a buffer swap occurs

Behaviour:
- Reset (asynchronous, immediate on rst_n low):
  - cnt=0, refreshcounter=0, pending and active buffers = 0, pending_full=0, state=OFF.
  - anode=4'b1111, nibble=0, dp_n=1, frame_done=0, load_ready=1.
  - Reset mid-operation discards pending and active data; the display goes dark at once.
- Prescaler:
  - cnt counts 0..PRESCALE-1 and wraps.
  - On the wrap cycle refreshcounter increments, with 3 wrapping to 0.
  - cnt and refreshcounter run in all states.
- Frame boundary: the cycle with cnt==PRESCALE-1 and refreshcounter==3.
- FSM states:
  - OFF: anode=1111 and dp_n=1. Leave OFF at the first frame boundary with pending_full=1, into BLANK.
  - BLANK: entered whenever cnt==0 (outside OFF). anode=1111, dp_n=1. Go to DRIVE when cnt==BLANK_CYCLES.
  - DRIVE: anode has bit[refreshcounter]=0 and all other bits 1, unless the digit is suppressed. Go to BLANK when cnt wraps.
  - OFF is re-entered only by reset.
- Digit suppression, DRIVE only: digit i is suppressed if either condition holds:
  - digit_en[i]=0;
  - lz_blank=1, i>=1, and nibbles i..3 of the active buffer are all zero.
  - Digit 0 is never lz-blanked.
  - A suppressed digit gives anode=1111 and dp_n=1.
- Data outputs:
  - nibble = active[4*refreshcounter +: 4] in every state.
  - dp_n = ~active_dp[refreshcounter] in DRIVE for an unsuppressed digit, otherwise 1.
- Timing: all outputs are registered and update on the same edge as refreshcounter/cnt. Checks are made relative to the registered refreshcounter.
- Handshake:
  - load_ready = ~pending_full.
  - On valid&&ready: load_value/load_dp are captured into pending and pending_full is set.
  - While pending_full=1, load_ready=0 and the producer must hold its data.
  - load_valid while ready=0 has no effect.
- Swap at a frame boundary with pending_full=1:
  - active <= pending, pending_full <= 0, frame_done=1 for that cycle.
  - A load accepted in the boundary cycle itself (pending empty at that point) stays in pending and swaps at the next boundary.
  - No swap occurs at a boundary with pending empty, and frame_done stays 0.
- Frame period = 4*PRESCALE cycles. Maximum load acceptance rate = one per frame.

Test Plan:
- Use PRESCALE=8, BLANK_CYCLES=2 throughout.
1. Reset then idle, no load -> anode=1111 forever; refreshcounter cycles 0,1,2,3 every 8 clocks; load_ready=1; frame_done=0.
2. Load 16'h1234, dp=4'b0100, digit_en=1111 -> ready falls next cycle; at the next boundary frame_done pulses and ready returns to 1. Then each slot shows 2 cycles of 1111 followed by 6 cycles of 1110/nibble 4, 1101/3, 1011/2 with dp_n=0, 0111/1.
3. Load 16'h0070, lz_blank=1 -> digits 3 and 2 stay 1111 in DRIVE; digit 1 shows 7; digit 0 shows 0. Clear lz_blank mid-frame -> digit 2 shows 0 starting from its next slot.
4. Two back-to-back loads, A=16'hAAAA then B=16'hBBBB -> B is held with ready=0 until A swaps; B is displayed one frame after A. No value is lost or torn within a frame.
5. Load presented exactly on a boundary cycle with pending empty -> accepted, no frame_done that cycle, swap and frame_done at the following boundary.
6. Assert rst_n low in the middle of a DRIVE slot -> anode=1111, dp_n=1 and refreshcounter=0 immediately, before the next clk edge. After release the display stays OFF until a new load is accepted and swapped.
